// File: rtl/ysyx_22050243_pkg.sv
// Shared definitions for the npc writeback/trap slice:
// CSR addresses, csr_op encodings, cause codes, WB bus layout.
package ysyx_22050243_pkg;

  localparam logic [11:0] CSR_MSTATUS  = 12'h300;
  localparam logic [11:0] CSR_MIE      = 12'h304;
  localparam logic [11:0] CSR_MTVEC    = 12'h305;
  localparam logic [11:0] CSR_MSCRATCH = 12'h340;
  localparam logic [11:0] CSR_MEPC     = 12'h341;
  localparam logic [11:0] CSR_MCAUSE   = 12'h342;
  localparam logic [11:0] CSR_MIP      = 12'h344;
  localparam logic [11:0] CSR_MCYCLE   = 12'hB00;
  localparam logic [11:0] CSR_MINSTRET = 12'hB02;
  localparam logic [11:0] CSR_MHARTID  = 12'hF14;

  localparam logic [2:0] CSR_OP_NONE = 3'd0;
  localparam logic [2:0] CSR_OP_RW   = 3'd1;
  localparam logic [2:0] CSR_OP_RS   = 3'd2;
  localparam logic [2:0] CSR_OP_RC   = 3'd3;
  localparam logic [2:0] CSR_OP_RWI  = 3'd5;
  localparam logic [2:0] CSR_OP_RSI  = 3'd6;
  localparam logic [2:0] CSR_OP_RCI  = 3'd7;

  localparam int MCAUSE_MTI     = 7;
  localparam int MCAUSE_ECALL_M = 11;
  localparam int IRQ_MTI_BIT    = 7;

  // Bus packed LSB-first: result, rd, reg_wen, pc, csr_addr,
  // csr_op, csr_src, uimm, ecall, mret, ebreak.
  function automatic int wb_bus_w(int xlen, int pc_w);
    return 2 * xlen + pc_w + 29;
  endfunction

  function automatic int off_rd(int xlen);
    return xlen;
  endfunction

  function automatic int off_wen(int xlen);
    return xlen + 5;
  endfunction

  function automatic int off_pc(int xlen);
    return xlen + 6;
  endfunction

  function automatic int off_csr_addr(int xlen, int pc_w);
    return xlen + pc_w + 6;
  endfunction

  function automatic int off_csr_op(int xlen, int pc_w);
    return xlen + pc_w + 18;
  endfunction

  function automatic int off_csr_src(int xlen, int pc_w);
    return xlen + pc_w + 21;
  endfunction

  function automatic int off_uimm(int xlen, int pc_w);
    return 2 * xlen + pc_w + 21;
  endfunction

  function automatic int off_ecall(int xlen, int pc_w);
    return 2 * xlen + pc_w + 26;
  endfunction

  function automatic int off_mret(int xlen, int pc_w);
    return 2 * xlen + pc_w + 27;
  endfunction

  function automatic int off_ebreak(int xlen, int pc_w);
    return 2 * xlen + pc_w + 28;
  endfunction

endpackage

// File: rtl/ysyx_22050243_gpr.sv
// 32 x XLEN register file, NRP combinational read ports,
// one write port forwarded to readers in the same cycle.
module ysyx_22050243_gpr #(
  parameter int XLEN = 64,
  parameter int NRP  = 2
) (
  input  logic                clk,
  input  logic                wen,
  input  logic [4:0]          waddr,
  input  logic [XLEN-1:0]     wdata,
  input  logic [NRP*5-1:0]    raddr,
  output logic [NRP*XLEN-1:0] rdata
);

  logic [XLEN-1:0] rf [32];

  always_ff @(posedge clk) begin
    if (wen && waddr != 5'd0) begin
      rf[waddr] <= wdata;
    end
  end

  for (genvar i = 0; i < NRP; i++) begin : g_rd
    logic [4:0] a;
    assign a = raddr[5*i +: 5];
    assign rdata[XLEN*i +: XLEN] =
      (a == 5'd0)            ? '0    :
      (wen && a == waddr)    ? wdata :
                               rf[a];
  end

endmodule

// File: rtl/ysyx_22050243_wb_trap.sv
// Writeback stage: WB slot, GPR file, M-mode CSRs and
// precise trap/mret handling with a registered PC redirect.
module ysyx_22050243_wb_trap
  import ysyx_22050243_pkg::*;
#(
  parameter int XLEN   = 64,
  parameter int PC_W   = 32,
  parameter int NRP    = 2,
  parameter int VEC_EN = 1
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           mem_to_wb_valid,
  input  logic [wb_bus_w(XLEN,PC_W)-1:0] mem_to_wb_bus,
  input  logic                           mem_flush,
  output logic                           wb_allowin,
  input  logic [NRP*5-1:0]               raddr,
  output logic [NRP*XLEN-1:0]            rdata,
  input  logic                           timer_irq,
  output logic                           wb_redirect_valid,
  output logic [PC_W-1:0]                wb_redirect_pc,
  output logic                           wb_commit,
  output logic [PC_W-1:0]                wb_pc,
  output logic [4:0]                     wb_rd,
  output logic                           wb_reg_wen,
  output logic [XLEN-1:0]                wb_reg_wdata,
  output logic                           wb_ebreak
);

  localparam int BW = wb_bus_w(XLEN, PC_W);
  localparam logic READY_GO = 1'b1;

  logic            wb_valid_q, wb_valid_d;
  logic [BW-1:0]   slot_q, slot_d;
  logic            mtip_q, mtip_d;
  logic            mst_mie_q, mst_mie_d;
  logic            mst_mpie_q, mst_mpie_d;
  logic [1:0]      mst_mpp_q, mst_mpp_d;
  logic [XLEN-1:0] mie_q, mie_d;
  logic [XLEN-1:0] mtvec_q, mtvec_d;
  logic [XLEN-1:0] mscratch_q, mscratch_d;
  logic [XLEN-1:0] mepc_q, mepc_d;
  logic [XLEN-1:0] mcause_q, mcause_d;
  logic [XLEN-1:0] mcycle_q, mcycle_d;
  logic [XLEN-1:0] minstret_q, minstret_d;
  logic            redir_valid_q, redir_valid_d;
  logic [PC_W-1:0] redir_pc_q, redir_pc_d;

  logic [XLEN-1:0] s_result, s_csr_src;
  logic [4:0]      s_rd, s_uimm;
  logic            s_wen, s_ecall, s_mret, s_ebreak;
  logic [PC_W-1:0] s_pc;
  logic [11:0]     s_caddr;
  logic [2:0]      s_cop;

  assign s_result  = slot_q[0 +: XLEN];
  assign s_rd      = slot_q[off_rd(XLEN) +: 5];
  assign s_wen     = slot_q[off_wen(XLEN)];
  assign s_pc      = slot_q[off_pc(XLEN) +: PC_W];
  assign s_caddr   = slot_q[off_csr_addr(XLEN,PC_W) +: 12];
  assign s_cop     = slot_q[off_csr_op(XLEN,PC_W) +: 3];
  assign s_csr_src = slot_q[off_csr_src(XLEN,PC_W) +: XLEN];
  assign s_uimm    = slot_q[off_uimm(XLEN,PC_W) +: 5];
  assign s_ecall   = slot_q[off_ecall(XLEN,PC_W)];
  assign s_mret    = slot_q[off_mret(XLEN,PC_W)];
  assign s_ebreak  = slot_q[off_ebreak(XLEN,PC_W)];

  logic irq_take, ecall_take, mret_take, trap_take, commit;
  logic csr_act, csr_wen, gpr_wen;
  logic [XLEN-1:0] csr_src, csr_rdata, csr_wval;
  logic [XLEN-1:0] mstatus_v, mip_v, pc_ext;
  logic [PC_W-1:0] vec_pc;

  assign irq_take   = wb_valid_q & mst_mie_q
                    & mie_q[IRQ_MTI_BIT] & mtip_q;
  assign ecall_take = wb_valid_q & s_ecall & ~irq_take;
  assign mret_take  = wb_valid_q & s_mret & ~irq_take;
  assign trap_take  = irq_take | ecall_take;
  assign commit     = wb_valid_q & ~irq_take;

  assign csr_act = s_cop[1:0] != 2'b00;
  assign csr_src = s_cop[2] ? XLEN'(s_uimm) : s_csr_src;
  assign csr_wen = commit & ~s_ecall & csr_act
                 & ~(s_cop[1] & (csr_src == '0));
  assign gpr_wen = commit & ~s_ecall & s_wen & (s_rd != 5'd0);

  always_comb begin
    mstatus_v = '0;
    mstatus_v[12:11] = mst_mpp_q;
    mstatus_v[7] = mst_mpie_q;
    mstatus_v[3] = mst_mie_q;
    mip_v = '0;
    mip_v[IRQ_MTI_BIT] = mtip_q;
    case (s_caddr)
      CSR_MSTATUS:  csr_rdata = mstatus_v;
      CSR_MIE:      csr_rdata = mie_q;
      CSR_MTVEC:    csr_rdata = mtvec_q;
      CSR_MSCRATCH: csr_rdata = mscratch_q;
      CSR_MEPC:     csr_rdata = mepc_q;
      CSR_MCAUSE:   csr_rdata = mcause_q;
      CSR_MIP:      csr_rdata = mip_v;
      CSR_MCYCLE:   csr_rdata = mcycle_q;
      CSR_MINSTRET: csr_rdata = minstret_q;
      CSR_MHARTID:  csr_rdata = '0;
      default:      csr_rdata = '0;
    endcase
  end

  always_comb begin
    case (s_cop[1:0])
      2'b01:   csr_wval = csr_src;
      2'b10:   csr_wval = csr_rdata | csr_src;
      2'b11:   csr_wval = csr_rdata & ~csr_src;
      default: csr_wval = csr_rdata;
    endcase
  end

  assign pc_ext = XLEN'(s_pc);

  always_comb begin
    vec_pc = {mtvec_q[PC_W-1:2], 2'b00};
    if (irq_take && VEC_EN != 0 && mtvec_q[1:0] == 2'b01) begin
      vec_pc = vec_pc + PC_W'(4 * MCAUSE_MTI);
    end
  end

  always_comb begin
    wb_valid_d    = wb_valid_q;
    slot_d        = slot_q;
    mtip_d        = timer_irq;
    mst_mie_d     = mst_mie_q;
    mst_mpie_d    = mst_mpie_q;
    mst_mpp_d     = mst_mpp_q;
    mie_d         = mie_q;
    mtvec_d       = mtvec_q;
    mscratch_d    = mscratch_q;
    mepc_d        = mepc_q;
    mcause_d      = mcause_q;
    mcycle_d      = mcycle_q + XLEN'(1);
    minstret_d    = minstret_q + XLEN'(commit);
    redir_valid_d = trap_take | mret_take;
    redir_pc_d    = '0;

    // A trap/mret in WB also kills the younger op arriving now.
    if (wb_allowin) begin
      wb_valid_d = mem_to_wb_valid & ~mem_flush
                 & ~(trap_take | mret_take);
      if (mem_to_wb_valid) slot_d = mem_to_wb_bus;
    end

    if (csr_wen) begin
      case (s_caddr)
        CSR_MSTATUS: begin
          mst_mie_d  = csr_wval[3];
          mst_mpie_d = csr_wval[7];
          mst_mpp_d  = csr_wval[12:11];
        end
        CSR_MIE:      mie_d      = csr_wval;
        CSR_MTVEC:    mtvec_d    = csr_wval;
        CSR_MSCRATCH: mscratch_d = csr_wval;
        CSR_MEPC:     mepc_d     = {csr_wval[XLEN-1:1], 1'b0};
        CSR_MCAUSE:   mcause_d   = csr_wval;
        CSR_MCYCLE:   mcycle_d   = csr_wval;
        CSR_MINSTRET: minstret_d = csr_wval;
        default: ;
      endcase
    end

    unique case (1'b1)
      trap_take: begin
        mepc_d     = {pc_ext[XLEN-1:1], 1'b0};
        mcause_d   = irq_take ? {1'b1, (XLEN-1)'(MCAUSE_MTI)}
                              : XLEN'(MCAUSE_ECALL_M);
        mst_mpie_d = mst_mie_q;
        mst_mie_d  = 1'b0;
        mst_mpp_d  = 2'b11;
        redir_pc_d = vec_pc;
      end
      mret_take: begin
        mst_mie_d  = mst_mpie_q;
        mst_mpie_d = 1'b1;
        mst_mpp_d  = 2'b11;
        redir_pc_d = mepc_q[PC_W-1:0];
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wb_valid_q    <= 1'b0;
      slot_q        <= '0;
      mtip_q        <= 1'b0;
      mst_mie_q     <= 1'b0;
      mst_mpie_q    <= 1'b0;
      mst_mpp_q     <= 2'b11;
      mie_q         <= '0;
      mtvec_q       <= '0;
      mscratch_q    <= '0;
      mepc_q        <= '0;
      mcause_q      <= '0;
      mcycle_q      <= '0;
      minstret_q    <= '0;
      redir_valid_q <= 1'b0;
      redir_pc_q    <= '0;
    end else begin
      wb_valid_q    <= wb_valid_d;
      slot_q        <= slot_d;
      mtip_q        <= mtip_d;
      mst_mie_q     <= mst_mie_d;
      mst_mpie_q    <= mst_mpie_d;
      mst_mpp_q     <= mst_mpp_d;
      mie_q         <= mie_d;
      mtvec_q       <= mtvec_d;
      mscratch_q    <= mscratch_d;
      mepc_q        <= mepc_d;
      mcause_q      <= mcause_d;
      mcycle_q      <= mcycle_d;
      minstret_q    <= minstret_d;
      redir_valid_q <= redir_valid_d;
      redir_pc_q    <= redir_pc_d;
    end
  end

  assign wb_allowin        = ~wb_valid_q | READY_GO;
  assign wb_redirect_valid = redir_valid_q;
  assign wb_redirect_pc    = redir_pc_q;
  assign wb_commit         = commit;
  assign wb_pc             = s_pc;
  assign wb_reg_wen        = gpr_wen;
  assign wb_rd             = gpr_wen ? s_rd : 5'd0;
  assign wb_reg_wdata      = !gpr_wen ? '0
                           : csr_act ? csr_rdata : s_result;
  assign wb_ebreak         = commit & s_ebreak;

  ysyx_22050243_gpr #(
    .XLEN (XLEN),
    .NRP  (NRP)
  ) u_gpr (
    .clk   (clk),
    .wen   (gpr_wen),
    .waddr (s_rd),
    .wdata (wb_reg_wdata),
    .raddr (raddr),
    .rdata (rdata)
  );

endmodule
